// File: rtl/cnn_layer_accel_layer_engine_pe_buffered_if.sv
// Handshake bundle for the buffered layer-engine PE: per-lane rd/wr ingress and
// egress streams plus the per-lane accepted-packet counters.
interface cnn_layer_accel_layer_engine_pe_buffered_if #(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_PE       = 4,
  parameter int C_CNT_WIDTH    = 16
);
  logic [C_NUM_PE-1:0]                layer_eng_rd_input_valid;
  logic [C_NUM_PE-1:0]                layer_eng_rd_input_accept;
  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_rd_input_data;
  logic [C_NUM_PE-1:0]                layer_eng_rd_output_valid;
  logic [C_NUM_PE-1:0]                layer_eng_rd_output_accept;
  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_rd_output_data;

  logic [C_NUM_PE-1:0]                layer_eng_wr_input_valid;
  logic [C_NUM_PE-1:0]                layer_eng_wr_input_accept;
  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_wr_input_data;
  logic [C_NUM_PE-1:0]                layer_eng_wr_output_valid;
  logic [C_NUM_PE-1:0]                layer_eng_wr_output_accept;
  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_wr_output_data;

  logic [C_CNT_WIDTH*C_NUM_PE-1:0]    rd_pkt_count;
  logic [C_CNT_WIDTH*C_NUM_PE-1:0]    wr_pkt_count;

  // Master is the traffic source/sink around the engine; slave is the engine.
  modport master (
    output layer_eng_rd_input_valid, layer_eng_rd_input_data, layer_eng_rd_output_accept,
    output layer_eng_wr_input_valid, layer_eng_wr_input_data, layer_eng_wr_output_accept,
    input  layer_eng_rd_input_accept, layer_eng_rd_output_valid, layer_eng_rd_output_data,
    input  layer_eng_wr_input_accept, layer_eng_wr_output_valid, layer_eng_wr_output_data,
    input  rd_pkt_count, wr_pkt_count
  );

  modport slave (
    input  layer_eng_rd_input_valid, layer_eng_rd_input_data, layer_eng_rd_output_accept,
    input  layer_eng_wr_input_valid, layer_eng_wr_input_data, layer_eng_wr_output_accept,
    output layer_eng_rd_input_accept, layer_eng_rd_output_valid, layer_eng_rd_output_data,
    output layer_eng_wr_input_accept, layer_eng_wr_output_valid, layer_eng_wr_output_data,
    output rd_pkt_count, wr_pkt_count
  );
endinterface

// File: rtl/cnn_layer_accel_layer_engine_pe_buffered.sv
// Buffered layer-engine PE: 2*C_NUM_PE independent lane FIFOs (rd and wr paths),
// each with a saturating accepted-packet counter, drop mode and synchronous flush.
module cnn_layer_accel_layer_engine_pe_buffered_lane #(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_FIFO_DEPTH   = 4,
  parameter int C_CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      drop_en,
  input  logic                      i_valid,
  output logic                      o_accept,
  input  logic [C_PACKET_WIDTH-1:0] i_data,
  output logic                      o_valid,
  input  logic                      i_accept,
  output logic [C_PACKET_WIDTH-1:0] o_data,
  output logic [C_CNT_WIDTH-1:0]    o_count
);
  localparam int C_AW = $clog2(C_FIFO_DEPTH);

  logic [C_PACKET_WIDTH-1:0] r_mem [C_FIFO_DEPTH];
  logic [C_AW-1:0]           r_wr_ptr;
  logic [C_AW-1:0]           r_rd_ptr;
  logic [C_AW:0]             r_occ;
  logic [C_CNT_WIDTH-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_xfer;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_occ == (C_AW+1)'(C_FIFO_DEPTH));
  assign w_empty = (r_occ == '0);

  // Accept never looks at i_valid; at full a same-cycle pop does not open the door.
  assign o_accept = !rst && !flush && (drop_en || !w_full);
  assign w_xfer   = i_valid && o_accept;
  assign w_push   = w_xfer && !drop_en;
  assign w_pop    = !w_empty && i_accept;

  assign o_valid  = !w_empty;
  assign o_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_count  <= '0;
    end else begin
      if (w_xfer && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; occupancy defines validity and o_data is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

module cnn_layer_accel_layer_engine_pe_buffered #(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_PE       = 4,
  parameter int C_FIFO_DEPTH   = 4,
  parameter int C_CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic drop_en,
  cnn_layer_accel_layer_engine_pe_buffered_if.slave bus
);
  localparam int W = C_PACKET_WIDTH;
  localparam int CW = C_CNT_WIDTH;

  for (genvar g = 0; g < C_NUM_PE; g++) begin : g_lane
    cnn_layer_accel_layer_engine_pe_buffered_lane #(
      .C_PACKET_WIDTH (C_PACKET_WIDTH),
      .C_FIFO_DEPTH   (C_FIFO_DEPTH),
      .C_CNT_WIDTH    (C_CNT_WIDTH)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .drop_en  (drop_en),
      .i_valid  (bus.layer_eng_rd_input_valid[g]),
      .o_accept (bus.layer_eng_rd_input_accept[g]),
      .i_data   (bus.layer_eng_rd_input_data[g*W +: W]),
      .o_valid  (bus.layer_eng_rd_output_valid[g]),
      .i_accept (bus.layer_eng_rd_output_accept[g]),
      .o_data   (bus.layer_eng_rd_output_data[g*W +: W]),
      .o_count  (bus.rd_pkt_count[g*CW +: CW])
    );

    cnn_layer_accel_layer_engine_pe_buffered_lane #(
      .C_PACKET_WIDTH (C_PACKET_WIDTH),
      .C_FIFO_DEPTH   (C_FIFO_DEPTH),
      .C_CNT_WIDTH    (C_CNT_WIDTH)
    ) u_wr (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .drop_en  (drop_en),
      .i_valid  (bus.layer_eng_wr_input_valid[g]),
      .o_accept (bus.layer_eng_wr_input_accept[g]),
      .i_data   (bus.layer_eng_wr_input_data[g*W +: W]),
      .o_valid  (bus.layer_eng_wr_output_valid[g]),
      .i_accept (bus.layer_eng_wr_output_accept[g]),
      .o_data   (bus.layer_eng_wr_output_data[g*W +: W]),
      .o_count  (bus.wr_pkt_count[g*CW +: CW])
    );
  end
endmodule

// File: tb/tb_cnn_layer_accel_layer_engine_pe_buffered.sv
// Directed bench for the buffered layer-engine PE: reset, latency, backpressure,
// concurrent push/pop, drop mode, flush/reset and counter saturation.
module tb_cnn_layer_accel_layer_engine_pe_buffered;
  localparam int W  = 66;
  localparam int N  = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic drop_en;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cnn_layer_accel_layer_engine_pe_buffered_if #(.C_PACKET_WIDTH(W), .C_NUM_PE(N), .C_CNT_WIDTH(CW)) bus ();
  cnn_layer_accel_layer_engine_pe_buffered_if #(.C_PACKET_WIDTH(W), .C_NUM_PE(1), .C_CNT_WIDTH(4))  bus_sat ();

  cnn_layer_accel_layer_engine_pe_buffered #(
    .C_PACKET_WIDTH(W), .C_NUM_PE(N), .C_FIFO_DEPTH(4), .C_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .drop_en(drop_en), .bus(bus)
  );

  cnn_layer_accel_layer_engine_pe_buffered #(
    .C_PACKET_WIDTH(W), .C_NUM_PE(1), .C_FIFO_DEPTH(4), .C_CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .drop_en(drop_en), .bus(bus_sat)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.layer_eng_rd_input_valid   = '0;
    bus.layer_eng_rd_input_data    = '0;
    bus.layer_eng_rd_output_accept = '0;
    bus.layer_eng_wr_input_valid   = '0;
    bus.layer_eng_wr_input_data    = '0;
    bus.layer_eng_wr_output_accept = '0;
    bus_sat.layer_eng_rd_input_valid   = '0;
    bus_sat.layer_eng_rd_input_data    = '0;
    bus_sat.layer_eng_rd_output_accept = '0;
    bus_sat.layer_eng_wr_input_valid   = '0;
    bus_sat.layer_eng_wr_input_data    = '0;
    bus_sat.layer_eng_wr_output_accept = '0;
    flush   = 1'b0;
    drop_en = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.layer_eng_rd_input_accept !== 4'h0 || bus.layer_eng_wr_input_accept !== 4'h0) begin
      bad++;
      $display("FAIL reset_accept: got rd=%h wr=%h want 0 0", bus.layer_eng_rd_input_accept, bus.layer_eng_wr_input_accept);
    end
    total++;
    if (bus.layer_eng_rd_output_valid !== 4'h0 || bus.layer_eng_wr_output_valid !== 4'h0) begin
      bad++;
      $display("FAIL reset_valid: got rd=%h wr=%h want 0 0", bus.layer_eng_rd_output_valid, bus.layer_eng_wr_output_valid);
    end
    total++;
    if (bus.layer_eng_rd_output_data !== '0 || bus.layer_eng_wr_output_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got rd=%h wr=%h want 0", bus.layer_eng_rd_output_data, bus.layer_eng_wr_output_data);
    end
    total++;
    if (bus.rd_pkt_count !== '0 || bus.wr_pkt_count !== '0) begin
      bad++;
      $display("FAIL reset_count: got rd=%h wr=%h want 0", bus.rd_pkt_count, bus.wr_pkt_count);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.layer_eng_rd_input_accept !== 4'hF || bus.layer_eng_wr_input_accept !== 4'hF) begin
      bad++;
      $display("FAIL post_reset_accept: got rd=%h wr=%h want f f", bus.layer_eng_rd_input_accept, bus.layer_eng_wr_input_accept);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0]      pkt;
    logic [W*N-1:0]    exp_data;
    logic [CW*N-1:0]   exp_cnt;
    do_reset();
    pkt = 66'h2_0000_0000_0000_0011;
    exp_data = '0;
    exp_data[2*W +: W] = pkt;
    exp_cnt = '0;
    exp_cnt[2*CW +: CW] = 16'd1;
    bus.layer_eng_rd_output_accept = 4'hF;
    bus.layer_eng_rd_input_valid   = 4'b0100;
    bus.layer_eng_rd_input_data[2*W +: W] = pkt;
    tick();
    bus.layer_eng_rd_input_valid = '0;
    total++;
    if (bus.layer_eng_rd_output_valid !== 4'b0100 || bus.layer_eng_rd_output_data !== exp_data) begin
      bad++;
      $display("FAIL basic_out: got valid=%h data=%h want valid=4 data=%h", bus.layer_eng_rd_output_valid, bus.layer_eng_rd_output_data, exp_data);
    end
    total++;
    if (bus.rd_pkt_count !== exp_cnt || bus.wr_pkt_count !== '0) begin
      bad++;
      $display("FAIL basic_count: got rd=%h wr=%h want rd=%h wr=0", bus.rd_pkt_count, bus.wr_pkt_count, exp_cnt);
    end
    tick();
    total++;
    if (bus.layer_eng_rd_output_valid !== 4'h0 || bus.layer_eng_rd_output_data !== '0) begin
      bad++;
      $display("FAIL basic_drained: got valid=%h data=%h want 0 0", bus.layer_eng_rd_output_valid, bus.layer_eng_rd_output_data);
    end
  endtask

  task automatic test_full();
    logic [W-1:0] pk [6];
    for (int k = 0; k < 6; k++) pk[k] = {2'b11, 64'hA000_0000_0000_0000} + 66'(k);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.layer_eng_wr_input_valid[0] = 1'b1;
      bus.layer_eng_wr_input_data[0 +: W] = pk[k];
      #1;
      total++;
      if (bus.layer_eng_wr_input_accept[0] !== 1'b1) begin
        bad++;
        $display("FAIL full_fill_accept: push %0d got %b want 1", k, bus.layer_eng_wr_input_accept[0]);
      end
      tick();
    end
    bus.layer_eng_wr_input_data[0 +: W] = pk[4];
    for (int k = 0; k < 2; k++) begin
      total++;
      if (bus.layer_eng_wr_input_accept[0] !== 1'b0 || bus.layer_eng_wr_output_data[0 +: W] !== pk[0]
          || bus.layer_eng_wr_output_valid[0] !== 1'b1) begin
        bad++;
        $display("FAIL full_hold: got accept=%b valid=%b data=%h want 0 1 %h", bus.layer_eng_wr_input_accept[0],
                 bus.layer_eng_wr_output_valid[0], bus.layer_eng_wr_output_data[0 +: W], pk[0]);
      end
      tick();
    end
    bus.layer_eng_wr_output_accept[0] = 1'b1;
    #1;
    total++;
    if (bus.layer_eng_wr_input_accept[0] !== 1'b0) begin
      bad++;
      $display("FAIL full_no_fallthrough: got accept=%b want 0", bus.layer_eng_wr_input_accept[0]);
    end
    tick();
    total++;
    if (bus.layer_eng_wr_input_accept[0] !== 1'b1 || bus.layer_eng_wr_output_data[0 +: W] !== pk[1]) begin
      bad++;
      $display("FAIL full_release: got accept=%b data=%h want 1 %h", bus.layer_eng_wr_input_accept[0],
               bus.layer_eng_wr_output_data[0 +: W], pk[1]);
    end
    tick();
    bus.layer_eng_wr_input_data[0 +: W] = pk[5];
    tick();
    bus.layer_eng_wr_input_valid[0] = 1'b0;
    for (int k = 3; k < 6; k++) begin
      total++;
      if (bus.layer_eng_wr_output_valid[0] !== 1'b1 || bus.layer_eng_wr_output_data[0 +: W] !== pk[k]) begin
        bad++;
        $display("FAIL full_order: slot %0d got valid=%b data=%h want 1 %h", k, bus.layer_eng_wr_output_valid[0],
                 bus.layer_eng_wr_output_data[0 +: W], pk[k]);
      end
      tick();
    end
    total++;
    if (bus.layer_eng_wr_output_valid[0] !== 1'b0 || bus.wr_pkt_count[0 +: CW] !== 16'd6) begin
      bad++;
      $display("FAIL full_end: got valid=%b count=%0d want 0 6", bus.layer_eng_wr_output_valid[0], bus.wr_pkt_count[0 +: CW]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s [12];
    for (int k = 0; k < 12; k++) s[k] = 66'h1_5500_0000_0000_0000 + 66'(k);
    do_reset();
    bus.layer_eng_rd_input_valid[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.layer_eng_rd_input_data[3*W +: W] = s[k];
      tick();
    end
    bus.layer_eng_rd_output_accept[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.layer_eng_rd_input_data[3*W +: W] = s[k+2];
      tick();
      total++;
      if (bus.layer_eng_rd_output_valid[3] !== 1'b1 || bus.layer_eng_rd_output_data[3*W +: W] !== s[k+1]
          || bus.layer_eng_rd_input_accept[3] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_stream: cycle %0d got valid=%b data=%h accept=%b want 1 %h 1", k,
                 bus.layer_eng_rd_output_valid[3], bus.layer_eng_rd_output_data[3*W +: W],
                 bus.layer_eng_rd_input_accept[3], s[k+1]);
      end
    end
    bus.layer_eng_rd_input_valid[3] = 1'b0;
    tick();
    total++;
    if (bus.layer_eng_rd_output_valid[3] !== 1'b1 || bus.layer_eng_rd_output_data[3*W +: W] !== s[11]) begin
      bad++;
      $display("FAIL b2b_tail: got valid=%b data=%h want 1 %h", bus.layer_eng_rd_output_valid[3],
               bus.layer_eng_rd_output_data[3*W +: W], s[11]);
    end
    tick();
    total++;
    if (bus.layer_eng_rd_output_valid[3] !== 1'b0 || bus.rd_pkt_count[3*CW +: CW] !== 16'd12) begin
      bad++;
      $display("FAIL b2b_empty: got valid=%b count=%0d want 0 12", bus.layer_eng_rd_output_valid[3], bus.rd_pkt_count[3*CW +: CW]);
    end
  endtask

  task automatic test_drop();
    logic [W-1:0]    p;
    logic [W-1:0]    q;
    logic [CW*N-1:0] exp_cnt;
    do_reset();
    p = 66'h0_1234_5678_9ABC_DEF0;
    q = 66'h3_FFFF_0000_FFFF_0000;
    bus.layer_eng_wr_input_valid[1] = 1'b1;
    bus.layer_eng_wr_input_data[1*W +: W] = p;
    tick();
    drop_en = 1'b1;
    bus.layer_eng_wr_input_data[1*W +: W] = q;
    tick();
    bus.layer_eng_wr_input_valid[1] = 1'b0;
    total++;
    if (bus.layer_eng_wr_output_valid !== 4'b0010 || bus.layer_eng_wr_output_data[1*W +: W] !== p
        || bus.wr_pkt_count[1*CW +: CW] !== 16'd2) begin
      bad++;
      $display("FAIL drop_midstream: got valid=%h data=%h count=%0d want 2 %h 2", bus.layer_eng_wr_output_valid,
               bus.layer_eng_wr_output_data[1*W +: W], bus.wr_pkt_count[1*CW +: CW], p);
    end
    bus.layer_eng_wr_output_accept = 4'hF;
    tick();
    total++;
    if (bus.layer_eng_wr_output_valid !== 4'h0) begin
      bad++;
      $display("FAIL drop_midstream_drain: got valid=%h want 0", bus.layer_eng_wr_output_valid);
    end
    do_reset();
    drop_en = 1'b1;
    bus.layer_eng_rd_output_accept = 4'hF;
    bus.layer_eng_wr_output_accept = 4'hF;
    bus.layer_eng_rd_input_valid   = 4'hF;
    bus.layer_eng_wr_input_valid   = 4'hF;
    for (int k = 0; k < 5; k++) begin
      bus.layer_eng_rd_input_data = {N{66'h2_AAAA_0000_0000_0000 + 66'(k)}};
      bus.layer_eng_wr_input_data = {N{66'h1_BBBB_0000_0000_0000 + 66'(k)}};
      tick();
      total++;
      if (bus.layer_eng_rd_output_valid !== 4'h0 || bus.layer_eng_wr_output_valid !== 4'h0
          || bus.layer_eng_rd_input_accept !== 4'hF || bus.layer_eng_wr_input_accept !== 4'hF) begin
        bad++;
        $display("FAIL drop_stream: cycle %0d got rdv=%h wrv=%h rda=%h wra=%h want 0 0 f f", k,
                 bus.layer_eng_rd_output_valid, bus.layer_eng_wr_output_valid,
                 bus.layer_eng_rd_input_accept, bus.layer_eng_wr_input_accept);
      end
    end
    bus.layer_eng_rd_input_valid = '0;
    bus.layer_eng_wr_input_valid = '0;
    exp_cnt = {N{16'd5}};
    total++;
    if (bus.rd_pkt_count !== exp_cnt || bus.wr_pkt_count !== exp_cnt) begin
      bad++;
      $display("FAIL drop_count: got rd=%h wr=%h want %h", bus.rd_pkt_count, bus.wr_pkt_count, exp_cnt);
    end
    drop_en = 1'b0;
    bus.layer_eng_rd_input_valid[0] = 1'b1;
    bus.layer_eng_rd_input_data[0 +: W] = p;
    tick();
    bus.layer_eng_rd_input_valid[0] = 1'b0;
    total++;
    if (bus.layer_eng_rd_output_valid !== 4'b0001 || bus.layer_eng_rd_output_data[0 +: W] !== p
        || bus.rd_pkt_count[0 +: CW] !== 16'd6) begin
      bad++;
      $display("FAIL drop_off_push: got valid=%h data=%h count=%0d want 1 %h 6", bus.layer_eng_rd_output_valid,
               bus.layer_eng_rd_output_data[0 +: W], bus.rd_pkt_count[0 +: CW], p);
    end
  endtask

  task automatic test_flush_reset();
    logic [CW*N-1:0] exp_cnt;
    do_reset();
    exp_cnt = '0;
    exp_cnt[1*CW +: CW] = 16'd3;
    bus.layer_eng_rd_input_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.layer_eng_rd_input_data[1*W +: W] = 66'h0_C0DE_0000_0000_0000 + 66'(k);
      tick();
    end
    bus.layer_eng_rd_input_valid[1] = 1'b0;
    total++;
    if (bus.rd_pkt_count !== exp_cnt || bus.layer_eng_rd_output_valid !== 4'b0010
        || bus.layer_eng_rd_output_data[1*W +: W] !== 66'h0_C0DE_0000_0000_0000) begin
      bad++;
      $display("FAIL flush_pre: got count=%h valid=%h data=%h", bus.rd_pkt_count, bus.layer_eng_rd_output_valid,
               bus.layer_eng_rd_output_data[1*W +: W]);
    end
    flush = 1'b1;
    #1;
    total++;
    if (bus.layer_eng_rd_input_accept !== 4'h0 || bus.layer_eng_wr_input_accept !== 4'h0) begin
      bad++;
      $display("FAIL flush_accept: got rd=%h wr=%h want 0 0", bus.layer_eng_rd_input_accept, bus.layer_eng_wr_input_accept);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (bus.layer_eng_rd_output_valid !== 4'h0 || bus.rd_pkt_count !== exp_cnt || bus.layer_eng_rd_input_accept !== 4'hF) begin
      bad++;
      $display("FAIL flush_post: got valid=%h count=%h accept=%h want 0 %h f", bus.layer_eng_rd_output_valid,
               bus.rd_pkt_count, bus.layer_eng_rd_input_accept, exp_cnt);
    end
    bus.layer_eng_rd_input_valid[1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (bus.layer_eng_rd_input_accept !== 4'h0) begin
      bad++;
      $display("FAIL rst_accept: got %h want 0", bus.layer_eng_rd_input_accept);
    end
    tick();
    total++;
    if (bus.rd_pkt_count !== '0 || bus.layer_eng_rd_output_valid !== 4'h0) begin
      bad++;
      $display("FAIL rst_clear: got count=%h valid=%h want 0 0", bus.rd_pkt_count, bus.layer_eng_rd_output_valid);
    end
    tick();
    rst = 1'b0;
    bus.layer_eng_rd_input_valid = '0;
    bus.layer_eng_rd_output_accept = 4'hF;
    #1;
    total++;
    if (bus.layer_eng_rd_input_accept !== 4'hF) begin
      bad++;
      $display("FAIL rst_release_accept: got %h want f", bus.layer_eng_rd_input_accept);
    end
    tick();
    tick();
    total++;
    if (bus.layer_eng_rd_output_valid !== 4'h0 || bus.layer_eng_rd_output_data !== '0) begin
      bad++;
      $display("FAIL rst_no_ghost: got valid=%h data=%h want 0 0", bus.layer_eng_rd_output_valid, bus.layer_eng_rd_output_data);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    do_reset();
    bus_sat.layer_eng_wr_output_accept = 1'b1;
    bus_sat.layer_eng_wr_input_valid   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus_sat.layer_eng_wr_input_data = 66'(k);
      tick();
      exp = (k > 15) ? 4'd15 : 4'(k);
      total++;
      if (bus_sat.wr_pkt_count !== exp) begin
        bad++;
        $display("FAIL sat_count: push %0d got %0d want %0d", k, bus_sat.wr_pkt_count, exp);
      end
    end
    bus_sat.layer_eng_wr_input_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_drop();
    test_flush_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_layer_engine_pe_buffered.md
CNN_LAYER_ACCEL_LAYER_ENGINE_PE_BUFFERED -- requirements
Module: cnn_layer_accel_layer_engine_pe_buffered

Interface
REQ-001 Parameter C_PACKET_WIDTH, default 66, bits per packet per lane.
REQ-002 Parameter C_NUM_PE, default 4, lanes per path (rd and wr); legal range 1..16.
REQ-003 Parameter C_FIFO_DEPTH, default 4, entries per lane FIFO; power of two, >= 2.
REQ-004 Parameter C_CNT_WIDTH, default 16, width of each per-lane packet counter.
REQ-005 Ports: clk  in  1  sole clock; all logic rising-edge. rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  synchronous clear of all lane FIFOs (both paths). drop_en  in  1  discard accepted packets instead of buffering.
REQ-007 layer_eng_rd_input_valid / layer_eng_rd_input_accept  in / out  C_NUM_PE  per-lane rd ingress handshake; layer_eng_rd_input_data  in  C_PACKET_WIDTH*C_NUM_PE  lane i at [i*C_PACKET_WIDTH +: C_PACKET_WIDTH].
REQ-008 layer_eng_rd_output_valid / layer_eng_rd_output_accept  out / in  C_NUM_PE  per-lane rd egress handshake; layer_eng_rd_output_data  out  C_PACKET_WIDTH*C_NUM_PE  same lane packing.
REQ-009 layer_eng_wr_input_valid, layer_eng_wr_input_accept, layer_eng_wr_input_data, layer_eng_wr_output_valid, layer_eng_wr_output_accept, layer_eng_wr_output_data: identical widths/directions/packing to rd counterparts.
REQ-010 rd_pkt_count, wr_pkt_count  out  C_CNT_WIDTH*C_NUM_PE  per-lane accepted-packet counters, lane i at [i*C_CNT_WIDTH +: C_CNT_WIDTH].

Function
REQ-011 Each of the 2*C_NUM_PE lanes SHALL be an independent FIFO of C_FIFO_DEPTH entries; no cross-lane or cross-path ordering dependency.
REQ-012 Ingress transfer on a lane SHALL occur on a rising edge where input_valid=1 and input_accept=1.
REQ-013 input_accept SHALL be 0 while rst=1 or flush=1; otherwise 1 when drop_en=1 or lane FIFO not full; derived from registered state and drop_en/flush/rst only, never from input_valid.
REQ-014 Full lane: input_accept=0 even if egress pops in the same cycle (no fall-through at full); the freed slot is accepted the next cycle.
REQ-015 drop_en=1 at transfer: packet discarded, FIFO unchanged, counter still increments.
REQ-016 drop_en=0 at transfer: packet written at tail; visible as output_valid=1 with that data the cycle after the transfer edge (latency 1 cycle), including when FIFO was empty.
REQ-017 output_valid SHALL be 1 iff lane FIFO non-empty; output_data SHALL equal head entry, and all-zero when empty.
REQ-018 Egress pop on a rising edge where output_valid=1 and output_accept=1; head advances; output_valid/output_data SHALL NOT change while output_accept=0 (stable until accepted).
REQ-019 Simultaneous push and pop on a non-full, non-empty lane: occupancy unchanged, order preserved; on an empty lane only the push takes effect.
REQ-020 Pointers SHALL wrap modulo C_FIFO_DEPTH; occupancy tracked with log2(C_FIFO_DEPTH)+1 bits to distinguish full from empty.
REQ-021 Per-lane counter SHALL increment by 1 on every ingress transfer, saturate at 2^C_CNT_WIDTH-1, not wrap.
REQ-022 flush=1 SHALL, at that edge, empty every FIFO (priority over push and pop); output_valid=0 the next cycle; counters NOT cleared.
REQ-023 drop_en change mid-stream SHALL not alter buffered contents; buffered packets keep draining normally.

Reset
REQ-024 rst=1 at an edge SHALL empty all FIFOs and clear all counters to 0; priority over flush, push, pop.
REQ-025 During and after reset: all output_valid=0, all output_data=0, all counts=0; input_accept=0 while rst=1, then 1 from the first cycle after rst deasserts (FIFOs empty).
REQ-026 Reset asserted mid-transfer SHALL discard in-flight and buffered packets; no packet emerges after reset that was accepted before it.

Verification
REQ-027 Basic: rd lane 2 push 0x2_0000_0000_0000_0011 cycle 0, output_accept=1 -> rd_output_valid[2]=1 with that data at cycle 1 only, rd_pkt_count lane 2=1, other lanes idle/0.
REQ-028 Full/backpressure: depth 4, output_accept=0, push 6 packets A..F on wr lane 0 -> accept drops after 4th, E held on input; release accept -> A,B,C,D then E,F out in order, count=6.
REQ-029 Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, sequence order intact, no gaps in output_valid.
REQ-030 Drop mode: drop_en=1, push 5 packets on all lanes -> output_valid stays 0, every count=5; drop_en=0 then push 1 -> emerges next cycle.
REQ-031 Flush/reset: 3 buffered on rd lane 1, counts=3; flush -> valid 0 next cycle, count still 3; rst -> count 0, accept 0 during rst, 1 after.
REQ-032 Saturation: C_CNT_WIDTH=4, 20 pushes on one lane -> count holds 15.
